// File: rtl/ball_physics.sv
// Pong ball/score engine: one update per rising edge of endofframe, outputs registered (1 clk after the tick edge).
// No backpressure; frame ticks are never missed or queued, extra endofframe high time is ignored.
module ball_physics #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int SPEED        = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk50M,
   input  logic       reset,
   input  logic       endofframe,
   input  logic [9:0] paddle_one_x,
   input  logic [9:0] paddle_one_y,
   input  logic [9:0] paddle_two_x,
   input  logic [9:0] paddle_two_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_one,
   output logic [3:0] score_two,
   output logic       game_over
);

   localparam logic [1:0] ST_SERVE = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_OVER  = 2'd2;

   localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic [10:0] SW = 11'(SCREEN_W);
   localparam logic [10:0] SH = 11'(SCREEN_H);
   localparam logic [10:0] BS = 11'(BALL_SIZE);
   localparam logic [10:0] PW = 11'(PADDLE_W);
   localparam logic [10:0] PH = 11'(PADDLE_H);
   localparam logic [10:0] SP = 11'(SPEED);
   localparam logic [9:0]  CX = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0]  CY = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [3:0]  WIN = 4'(WIN_SCORE);

   logic [1:0]    state;
   logic [CW-1:0] serve_cnt;
   logic          eof_q;
   logic          dir_right;
   logic          dir_down;
   logic          tick;

   logic [10:0] bx, by, p1r, p1y, p2x, p2y;
   logic        ov1, ov2;
   logic [9:0]  nxt_x, nxt_y;
   logic        nxt_dr, nxt_dd;
   logic        miss_l, miss_r;

   assign tick = endofframe & ~eof_q;

   // All geometry in 11 bits so edge sums near 1023 cannot wrap.
   assign bx  = {1'b0, ball_x};
   assign by  = {1'b0, ball_y};
   assign p1r = {1'b0, paddle_one_x} + PW;
   assign p1y = {1'b0, paddle_one_y};
   assign p2x = {1'b0, paddle_two_x};
   assign p2y = {1'b0, paddle_two_y};

   always_comb begin
      nxt_y  = ball_y;
      nxt_dd = dir_down;
      if (dir_down) begin
         if (by + BS + SP >= SH) begin
            nxt_y  = 10'(SH - BS);
            nxt_dd = 1'b0;
         end else begin
            nxt_y = 10'(by + SP);
         end
      end else if (by < SP) begin
         nxt_y  = 10'd0;
         nxt_dd = 1'b1;
      end else begin
         nxt_y = 10'(by - SP);
      end

      ov1 = (by + BS > p1y) && (by < p1y + PH);
      ov2 = (by + BS > p2y) && (by < p2y + PH);

      nxt_x  = ball_x;
      nxt_dr = dir_right;
      miss_l = 1'b0;
      miss_r = 1'b0;
      if (!dir_right) begin
         if (bx >= p1r && bx <= p1r + SP && ov1) begin
            nxt_x  = 10'(p1r);
            nxt_dr = 1'b1;
         end else if (bx < SP) begin
            miss_l = 1'b1;
         end else begin
            nxt_x = 10'(bx - SP);
         end
      end else begin
         if (bx + BS <= p2x && bx + BS + SP >= p2x && ov2) begin
            nxt_x  = 10'(p2x - BS);
            nxt_dr = 1'b0;
         end else if (bx + BS + SP >= SW) begin
            miss_r = 1'b1;
         end else begin
            nxt_x = 10'(bx + SP);
         end
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         eof_q     <= 1'b0;
         state     <= ST_SERVE;
         serve_cnt <= '0;
         ball_x    <= CX;
         ball_y    <= CY;
         dir_right <= 1'b1;
         dir_down  <= 1'b1;
         score_one <= 4'd0;
         score_two <= 4'd0;
         game_over <= 1'b0;
      end else begin
         eof_q <= endofframe;
         if (tick) begin
            case (state)
               ST_SERVE: begin
                  if (serve_cnt == CW'(SERVE_FRAMES - 1)) begin
                     state     <= ST_PLAY;
                     serve_cnt <= '0;
                  end else begin
                     serve_cnt <= serve_cnt + CW'(1);
                  end
               end
               ST_PLAY: begin
                  // A point drops this tick's vertical move and re-serves toward the loser.
                  if (miss_l || miss_r) begin
                     ball_x    <= CX;
                     ball_y    <= CY;
                     dir_right <= miss_r;
                     if (miss_l) score_two <= score_two + 4'd1;
                     else        score_one <= score_one + 4'd1;
                     if ((miss_l && score_two + 4'd1 == WIN) ||
                         (miss_r && score_one + 4'd1 == WIN)) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                     end else begin
                        state <= ST_SERVE;
                     end
                  end else begin
                     ball_x    <= nxt_x;
                     ball_y    <= nxt_y;
                     dir_right <= nxt_dr;
                     dir_down  <= nxt_dd;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_physics.sv
// Randomized frame-level bench for ball_physics against a per-frame integer model.
module tb_ball_physics;

   localparam int W = 640, H = 480, BS = 8, PW = 8, PH = 64, SP = 2;
   localparam int SF = 3, WS = 3;
   localparam int CX = (W - BS) / 2, CY = (H - BS) / 2;

   logic       clk50M = 1'b0;
   logic       reset = 1'b1;
   logic       endofframe = 1'b0;
   logic [9:0] paddle_one_x = 10'd16, paddle_one_y = 10'd0;
   logic [9:0] paddle_two_x = 10'd616, paddle_two_y = 10'd0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_one, score_two;
   logic       game_over;

   int n_checks = 0;
   int n_errors = 0;

   // model: phase 0 serve, 1 play, 2 over; dr=1 moving right, dd=1 moving down
   int mx, my, mdr, mdd, ms1, ms2, mph, mcnt;

   ball_physics #(
      .SCREEN_W(W), .SCREEN_H(H), .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
      .SPEED(SP), .SERVE_FRAMES(SF), .WIN_SCORE(WS)
   ) dut (
      .clk50M(clk50M), .reset(reset), .endofframe(endofframe),
      .paddle_one_x(paddle_one_x), .paddle_one_y(paddle_one_y),
      .paddle_two_x(paddle_two_x), .paddle_two_y(paddle_two_y),
      .ball_x(ball_x), .ball_y(ball_y),
      .score_one(score_one), .score_two(score_two), .game_over(game_over)
   );

   always #10 clk50M = ~clk50M;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk50M);
      #1;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".ball_x"}, int'(ball_x), mx);
      check_val({tag, ".ball_y"}, int'(ball_y), my);
      check_val({tag, ".score_one"}, int'(score_one), ms1);
      check_val({tag, ".score_two"}, int'(score_two), ms2);
      check_val({tag, ".game_over"}, int'(game_over), (mph == 2) ? 1 : 0);
   endtask

   task automatic model_reset();
      mx = CX; my = CY; mdr = 1; mdd = 1;
      ms1 = 0; ms2 = 0; mph = 0; mcnt = 0;
   endtask

   task automatic model_point(input bit left_scores);
      mx = CX; my = CY;
      mdr = left_scores ? 1 : 0;
      if (left_scores) ms1++; else ms2++;
      mph = ((left_scores ? ms1 : ms2) == WS) ? 2 : 0;
      mcnt = 0;
   endtask

   // One frame of game rules, using the paddle inputs currently driven.
   task automatic model_frame();
      int ny, ndd, p1x, p1y, p2x, p2y;
      bit ov1, ov2;
      p1x = int'(paddle_one_x); p1y = int'(paddle_one_y);
      p2x = int'(paddle_two_x); p2y = int'(paddle_two_y);
      if (mph == 0) begin
         if (mcnt == SF - 1) begin mph = 1; mcnt = 0; end
         else mcnt++;
      end else if (mph == 1) begin
         ndd = mdd;
         if (mdd == 1 && my + BS + SP >= H) begin ny = H - BS; ndd = 0; end
         else if (mdd == 0 && my < SP) begin ny = 0; ndd = 1; end
         else ny = (mdd == 1) ? my + SP : my - SP;
         ov1 = (my + BS > p1y) && (my < p1y + PH);
         ov2 = (my + BS > p2y) && (my < p2y + PH);
         if (mdr == 0) begin
            if (mx >= p1x + PW && mx - SP <= p1x + PW && ov1) begin
               mx = p1x + PW; mdr = 1; my = ny; mdd = ndd;
            end else if (mx < SP) model_point(1'b0);
            else begin mx = mx - SP; my = ny; mdd = ndd; end
         end else begin
            if (mx + BS <= p2x && mx + BS + SP >= p2x && ov2) begin
               mx = p2x - BS; mdr = 0; my = ny; mdd = ndd;
            end else if (mx + BS + SP >= W) model_point(1'b1);
            else begin mx = mx + SP; my = ny; mdd = ndd; end
         end
      end
   endtask

   task automatic do_frame(input int hi, input int lo, input string tag);
      endofframe = 1'b1;
      repeat (hi) cyc();
      endofframe = 1'b0;
      repeat (lo) cyc();
      model_frame();
      check_all(tag);
   endtask

   task automatic do_reset(input bit eof_during);
      reset = 1'b1;
      endofframe = eof_during;
      cyc();
      reset = 1'b0;
      endofframe = 1'b0;
      cyc();
      model_reset();
   endtask

   function automatic logic [9:0] track_y(input int by);
      int y;
      y = by - int'($urandom_range(0, 62)) + 4;
      if (y < 0) y = 0;
      if (y > H - PH) y = H - PH;
      return 10'(y);
   endfunction

   initial begin
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      model_reset();
      check_all("reset");

      // serve hold then release
      for (int i = 0; i < SF; i++) do_frame(2, 2, "serve");
      check_val("serve_hold_x", int'(ball_x), 316);
      check_val("serve_hold_y", int'(ball_y), 236);
      do_frame(1, 3, "release");
      check_val("release_x", int'(ball_x), 318);
      check_val("release_y", int'(ball_y), 238);

      // long endofframe: exactly one step
      model_frame();
      endofframe = 1'b1;
      cyc();
      check_val("hold_first_x", int'(ball_x), 320);
      repeat (199) cyc();
      check_val("hold_end_x", int'(ball_x), 320);
      check_val("hold_end_y", int'(ball_y), 240);
      endofframe = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) do_frame(1, 1, "pulse");
      check_val("pulse_x", int'(ball_x), 330);
      check_val("pulse_y", int'(ball_y), 250);

      // reset colliding with a frame edge wins
      do_reset(1'b1);
      check_all("reset_override");

      for (int f = 0; f < 2500; f++) begin
         if ($urandom_range(0, 9) < 8) begin
            paddle_one_y = track_y(my);
            paddle_two_y = track_y(my);
         end else begin
            paddle_one_y = 10'($urandom_range(0, H - PH));
            paddle_two_y = 10'($urandom_range(0, H - PH));
         end
         paddle_one_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40)) : 10'd16;
         paddle_two_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(590, 630)) : 10'd616;
         do_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), "rand");
         if (mph == 2 && $urandom_range(0, 3) == 0) begin
            do_frame(2, 1, "over_frozen");
            do_reset($urandom_range(0, 1) == 1);
            check_all("reset_after_over");
         end else if ($urandom_range(0, 499) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
            check_all("reset_mid");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
